forward_grant_scheduler: RTL and testbench
==========================================

FORWARD_GRANT_SCHEDULER -- requirements
Module: forward_grant_scheduler

Interface
REQ-001 Parameter P_PORT_NUM, default 4: number of forwarding requesters, legal range 2..8.
REQ-002 Parameter P_TIMEOUT, default 32'd100000: watchdog limit in clock cycles, used only when the watchdog is compiled in.
REQ-003 i_clk  input  1  single clock; all logic on its rising edge.
REQ-004 i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_slot_start  input  1  one-cycle pulse marking the start of a transmit slot.
REQ-006 i_slot_byte  input  32  byte budget of the slot; sampled with i_slot_start.
REQ-007 i_forward_req  input  P_PORT_NUM  per-port level request; each port holds it until granted.
REQ-008 i_forward_finish  input  P_PORT_NUM  per-port finish level; high means that port's budget is exhausted or that port is idle.
REQ-009 o_forward_resp  output  P_PORT_NUM  one-hot grant pulse.
REQ-010 o_forward_byte  output  32  granted byte budget, shared by all ports.
REQ-011 o_forward_byte_valid  output  P_PORT_NUM  one-hot budget-valid pulse.
REQ-012 o_grant_id  output  3  index of the current or last winner.
REQ-013 o_busy  output  1  high from the grant until completion.
REQ-014 o_slot_done  output  1  one-cycle pulse when a granted slot completes.
REQ-015 o_slot_overrun  output  1  one-cycle pulse when i_slot_start is dropped.
REQ-016 o_timeout  output  1  one-cycle watchdog abort pulse; tied to 0 when the watchdog is compiled out.

Function
REQ-017 The FSM SHALL have states IDLE, ARB, GRANT and BUSY, all registered.
REQ-018 IDLE: on i_slot_start with i_slot_byte != 0, latch the budget and go to ARB next cycle. A zero budget is ignored, with no pulse and no state change.
REQ-019 ARB: stay in ARB while i_forward_req == 0; otherwise select the winner round-robin, starting the search at rr_ptr and wrapping modulo P_PORT_NUM, then go to GRANT.
REQ-020 GRANT (exactly 1 cycle):
- o_forward_resp[winner] = 1 and o_forward_byte_valid[winner] = 1.
- o_forward_byte = latched budget.
- o_grant_id = winner.
- Next state BUSY.
REQ-021 Grant latency: o_forward_resp asserts 2 cycles after i_slot_start when a request is already pending; otherwise 1 cycle after the first ARB cycle that sees a request.
REQ-022 BUSY: a seen_low flag is set when i_forward_finish[winner] == 0. Completion is i_forward_finish[winner] == 1 with seen_low set; the initial high level of finish SHALL NOT complete the slot.
REQ-023 On completion: o_slot_done pulses for 1 cycle, rr_ptr becomes (winner+1) mod P_PORT_NUM, seen_low clears, and the FSM returns to IDLE.
REQ-024 o_busy SHALL equal (state == GRANT or state == BUSY).
REQ-025 An i_slot_start in ARB, GRANT or BUSY SHALL be dropped with a 1-cycle o_slot_overrun pulse; the latched budget is unchanged.
REQ-026 Requests from non-winning ports SHALL be ignored outside ARB; the winner's finish is the only finish input observed.
REQ-027 o_forward_byte SHALL hold its last value outside GRANT; the resp and valid vectors SHALL be zero outside GRANT.

Reset
REQ-028 Asserting i_rst_n low SHALL immediately force the following, including mid-grant:
- state to IDLE
- all outputs to 0
- rr_ptr to 0, the budget register to 0, seen_low to 0, the watchdog counter to 0.
REQ-029 The first i_slot_start after i_rst_n deasserts SHALL be accepted normally.

Configuration
REQ-030 With macro FWD_SCHED_TIMEOUT_EN defined:
- A 32-bit counter clears on entry to GRANT and increments every BUSY cycle.
- When the counter reaches P_TIMEOUT, o_timeout pulses for 1 cycle and the FSM returns to IDLE.
- rr_ptr advances past the winner, and o_slot_done does not pulse.
REQ-031 Without FWD_SCHED_TIMEOUT_EN: no counter is built, o_timeout is constant 0, and BUSY waits indefinitely for completion.

Verification
REQ-032 Port 1 request pending; i_slot_start with i_slot_byte=3036 -> 2 cycles later resp[1], valid[1] and byte=3036 for 1 cycle. Finish[1] drops then rises -> o_slot_done 1 cycle, rr_ptr=2.
REQ-033 All 4 ports requesting; 4 slots, each completed -> grant order 0,1,2,3, then port 0 on the 5th slot.
REQ-034 Slot start with no request; request on port 2 appears 10 cycles later -> resp[2] on the following cycle with the original budget. A slot start during the wait -> o_slot_overrun pulse, budget unchanged.
REQ-035 i_slot_byte=0 -> no state change and no pulses. Finish[winner] held high through BUSY without ever dropping -> no completion.
REQ-036 Reset asserted in BUSY -> all outputs 0 immediately; next slot grants port 0.
REQ-037 With FWD_SCHED_TIMEOUT_EN and P_TIMEOUT=50: finish never drops -> o_timeout 1 cycle after 50 BUSY cycles, no o_slot_done, and the next grant goes to winner+1.

Source files
------------

// File: rtl/forward_grant_scheduler.sv
// Round-robin forwarding grant scheduler: one granted requester per transmit slot.
// Optional watchdog abort of a stuck BUSY phase is built when FWD_SCHED_TIMEOUT_EN is defined.
module forward_grant_scheduler #(
    parameter int          P_PORT_NUM = 4,
    parameter logic [31:0] P_TIMEOUT  = 32'd100000
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_slot_start,
    input  logic [31:0]           i_slot_byte,
    input  logic [P_PORT_NUM-1:0] i_forward_req,
    input  logic [P_PORT_NUM-1:0] i_forward_finish,
    output logic [P_PORT_NUM-1:0] o_forward_resp,
    output logic [31:0]           o_forward_byte,
    output logic [P_PORT_NUM-1:0] o_forward_byte_valid,
    output logic [2:0]            o_grant_id,
    output logic                  o_busy,
    output logic                  o_slot_done,
    output logic                  o_slot_overrun,
    output logic                  o_timeout
);
    typedef enum logic [1:0] {S_IDLE, S_ARB, S_GRANT, S_BUSY} state_t;

    localparam logic [2:0] LAST_PORT = 3'(P_PORT_NUM - 1);
    localparam logic [3:0] PORT_CNT  = 4'(P_PORT_NUM);

    state_t                state_q, state_d;
    logic [31:0]           budget_q, budget_d;
    logic [31:0]           fwd_byte_q, fwd_byte_d;
    logic [2:0]            winner_q, winner_d;
    logic [2:0]            rr_ptr_q, rr_ptr_d;
    logic                  seen_low_q, seen_low_d;
    logic                  done_q, done_d;
    logic                  overrun_q, overrun_d;
    logic [P_PORT_NUM-1:0] req_rot;
    logic [3:0]            rr_sum;
    logic [2:0]            rr_pick;
    logic                  rr_found;
    logic [2:0]            rr_next;
    logic                  fin_w;
    logic                  complete;
    logic                  wdog_hit;
    logic [P_PORT_NUM-1:0] grant_vec;

    // Rotate requests so bit 0 is the rr_ptr port; the lowest set bit is the winner.
    always_comb begin
        req_rot  = P_PORT_NUM'({i_forward_req, i_forward_req} >> rr_ptr_q);
        rr_found = 1'b0;
        rr_sum   = '0;
        for (int i = P_PORT_NUM - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                rr_found = 1'b1;
                rr_sum   = {1'b0, rr_ptr_q} + 4'(i);
            end
        end
        if (rr_sum >= PORT_CNT) begin
            rr_sum = rr_sum - PORT_CNT;
        end
        rr_pick = rr_sum[2:0];
    end

    always_comb begin
        fin_w     = 1'b0;
        grant_vec = '0;
        for (int i = 0; i < P_PORT_NUM; i++) begin
            if (winner_q == 3'(i)) begin
                fin_w        = i_forward_finish[i];
                grant_vec[i] = (state_q == S_GRANT);
            end
        end
    end

    assign rr_next  = (winner_q == LAST_PORT) ? 3'd0 : winner_q + 3'd1;
    assign complete = (state_q == S_BUSY) && fin_w && seen_low_q;

    always_comb begin
        state_d    = state_q;
        budget_d   = budget_q;
        fwd_byte_d = fwd_byte_q;
        winner_d   = winner_q;
        rr_ptr_d   = rr_ptr_q;
        seen_low_d = seen_low_q;
        done_d     = 1'b0;
        overrun_d  = i_slot_start && (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (i_slot_start && (i_slot_byte != 32'd0)) begin
                    budget_d = i_slot_byte;
                    state_d  = S_ARB;
                end
            end
            S_ARB: begin
                if (rr_found) begin
                    winner_d   = rr_pick;
                    fwd_byte_d = budget_q;
                    state_d    = S_GRANT;
                end
            end
            S_GRANT: begin
                seen_low_d = 1'b0;
                state_d    = S_BUSY;
            end
            S_BUSY: begin
                if (!fin_w) begin
                    seen_low_d = 1'b1;
                end
                if (complete) begin
                    done_d     = 1'b1;
                    rr_ptr_d   = rr_next;
                    seen_low_d = 1'b0;
                    state_d    = S_IDLE;
                end else if (wdog_hit) begin
                    rr_ptr_d   = rr_next;
                    seen_low_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            budget_q   <= '0;
            fwd_byte_q <= '0;
            winner_q   <= '0;
            rr_ptr_q   <= '0;
            seen_low_q <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            budget_q   <= budget_d;
            fwd_byte_q <= fwd_byte_d;
            winner_q   <= winner_d;
            rr_ptr_q   <= rr_ptr_d;
            seen_low_q <= seen_low_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
        end
    end

`ifdef FWD_SCHED_TIMEOUT_EN
    logic [31:0] wdog_q;
    logic        timeout_q;

    // Completion wins over a watchdog hit landing in the same cycle.
    assign wdog_hit = (state_q == S_BUSY) && !complete && ((wdog_q + 32'd1) == P_TIMEOUT);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= wdog_hit;
            if ((state_q == S_ARB) && (state_d == S_GRANT)) begin
                wdog_q <= '0;
            end else if (state_q == S_BUSY) begin
                wdog_q <= wdog_q + 32'd1;
            end
        end
    end

    assign o_timeout = timeout_q;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = P_TIMEOUT;
    assign wdog_hit       = 1'b0;
    assign o_timeout      = 1'b0;
`endif

    assign o_forward_resp       = grant_vec;
    assign o_forward_byte_valid = grant_vec;
    assign o_forward_byte       = fwd_byte_q;
    assign o_grant_id           = winner_q;
    assign o_busy               = (state_q == S_GRANT) || (state_q == S_BUSY);
    assign o_slot_done          = done_q;
    assign o_slot_overrun       = overrun_q;
endmodule

// File: tb/tb_forward_grant_scheduler.sv
// Directed bench for forward_grant_scheduler with a grant scoreboard and a round-robin model.
// Covers the watchdog path when FWD_SCHED_TIMEOUT_EN is defined.
module tb_forward_grant_scheduler;
    localparam int NP = 4;
`ifdef FWD_SCHED_TIMEOUT_EN
    localparam logic [31:0] TB_TIMEOUT = 32'd50;
`else
    localparam logic [31:0] TB_TIMEOUT = 32'd100000;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          slot_start;
    logic [31:0]   slot_byte;
    logic [NP-1:0] fwd_req;
    logic [NP-1:0] fwd_finish;
    logic [NP-1:0] resp;
    logic [31:0]   fwd_byte;
    logic [NP-1:0] byte_valid;
    logic [2:0]    grant_id;
    logic          busy;
    logic          slot_done;
    logic          slot_overrun;
    logic          timeout;

    forward_grant_scheduler #(.P_PORT_NUM(NP), .P_TIMEOUT(TB_TIMEOUT)) dut (
        .i_clk                (clk),
        .i_rst_n              (rst_n),
        .i_slot_start         (slot_start),
        .i_slot_byte          (slot_byte),
        .i_forward_req        (fwd_req),
        .i_forward_finish     (fwd_finish),
        .o_forward_resp       (resp),
        .o_forward_byte       (fwd_byte),
        .o_forward_byte_valid (byte_valid),
        .o_grant_id           (grant_id),
        .o_busy               (busy),
        .o_slot_done          (slot_done),
        .o_slot_overrun       (slot_overrun),
        .o_timeout            (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic [31:0] bytes;
    } grant_t;

    grant_t exp_q[$];
    int cyc = 0;
    int n_pass = 0, n_fail = 0, n_checks = 0;
    int grants_seen = 0, done_cnt = 0, ovr_cnt = 0, tmo_cnt = 0;
    int grant_cyc = 0, tmo_cyc = 0, last_id = -1;
    int exp_rr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every grant pulse must match the oldest expected grant.
    always @(negedge clk) begin : monitor
        grant_t        e;
        logic [NP-1:0] onehot;
        if (resp != '0 || byte_valid != '0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_grant", 64'(resp), 64'd0);
            end else begin
                e = exp_q.pop_front();
                onehot = '0;
                onehot[e.port] = 1'b1;
                check("grant_resp", 64'(resp), 64'(onehot));
                check("grant_valid", 64'(byte_valid), 64'(onehot));
                check("grant_byte", 64'(fwd_byte), 64'(e.bytes));
                check("grant_id", 64'(grant_id), 64'(e.port));
            end
            grants_seen = grants_seen + 1;
            grant_cyc   = cyc;
            last_id     = int'(grant_id);
        end
        if (slot_done)    done_cnt = done_cnt + 1;
        if (slot_overrun) ovr_cnt  = ovr_cnt + 1;
        if (timeout) begin
            tmo_cnt = tmo_cnt + 1;
            tmo_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_slot(input logic [31:0] b);
        slot_byte  = b;
        slot_start = 1'b1;
        tick();
        slot_start = 1'b0;
    endtask

    task automatic wait_grant(input int target);
        for (int k = 0; k < 40 && grants_seen < target; k++) tick();
        check("grant_wait", 64'(grants_seen), 64'(target));
    endtask

    task automatic wait_done(input int target);
        for (int k = 0; k < 40 && done_cnt < target; k++) tick();
        check("done_wait", 64'(done_cnt), 64'(target));
    endtask

    function automatic int rr_model(input logic [NP-1:0] mask);
        for (int i = 0; i < NP; i++) begin
            int p;
            p = (exp_rr + i) % NP;
            if (mask[p]) return p;
        end
        return 0;
    endfunction

    // Requests pending before the slot start; winner completes with a low-then-high finish.
    task automatic run_slot(input logic [NP-1:0] mask, input logic [31:0] b);
        int w, g0, d0, s0;
        w = rr_model(mask);
        exp_q.push_back('{w, b});
        fwd_req = mask;
        g0 = grants_seen;
        d0 = done_cnt;
        s0 = cyc;
        pulse_slot(b);
        wait_grant(g0 + 1);
        check("grant_latency", 64'(grant_cyc - s0), 64'd2);
        check("busy_after_grant", 64'(busy), 64'd1);
        fwd_req[w] = 1'b0;
        tick();
        fwd_finish[w] = 1'b0;
        tick();
        tick();
        fwd_finish[w] = 1'b1;
        wait_done(d0 + 1);
        tick();
        tick();
        check("done_width", 64'(done_cnt), 64'(d0 + 1));
        check("busy_after_done", 64'(busy), 64'd0);
        check("byte_hold", 64'(fwd_byte), 64'(b));
        exp_rr = (w + 1) % NP;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_resp"}, 64'(resp), 64'd0);
        check({tag, "_valid"}, 64'(byte_valid), 64'd0);
        check({tag, "_byte"}, 64'(fwd_byte), 64'd0);
        check({tag, "_id"}, 64'(grant_id), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(slot_done), 64'd0);
        check({tag, "_overrun"}, 64'(slot_overrun), 64'd0);
        check({tag, "_timeout"}, 64'(timeout), 64'd0);
    endtask

    initial begin
        int g0, d0, o0, t0, rq;
        rst_n      = 1'b0;
        slot_start = 1'b0;
        slot_byte  = '0;
        fwd_req    = '0;
        fwd_finish = '1;
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Single request on port 1, then confirm rr_ptr moved to 2.
        run_slot(4'b0010, 32'd3036);
        check("A_winner", 64'(last_id), 64'd1);
        run_slot(4'b0110, 32'd64);
        check("A_rr_next", 64'(last_id), 64'd2);

        // Fresh reset, all ports requesting: 0,1,2,3 then 0 again.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_rr = 0;
        tick();
        for (int i = 0; i < 5; i++) begin
            run_slot(4'b1111, 32'd1000 + 32'(i));
            check("B_order", 64'(last_id), 64'(i % NP));
        end

        // Slot waits in ARB; an extra start is dropped; late request on port 2.
        fwd_req = '0;
        pulse_slot(32'd500);
        repeat (4) tick();
        check("C_busy_in_arb", 64'(busy), 64'd0);
        o0 = ovr_cnt;
        pulse_slot(32'd777);
        tick();
        tick();
        check("C_overrun", 64'(ovr_cnt), 64'(o0 + 1));
        repeat (3) tick();
        exp_q.push_back('{rr_model(4'b0100), 32'd500});
        g0 = grants_seen;
        d0 = done_cnt;
        fwd_req = 4'b0100;
        rq = cyc;
        wait_grant(g0 + 1);
        check("C_latency", 64'(grant_cyc - rq), 64'd1);
        check("C_winner", 64'(last_id), 64'd2);
        fwd_req = '0;
        tick();
        fwd_finish[2] = 1'b0;
        tick();
        tick();
        fwd_finish[2] = 1'b1;
        wait_done(d0 + 1);
        exp_rr = 3;
        tick();

        // Zero budget is ignored even with a request pending.
        fwd_req = 4'b0001;
        g0 = grants_seen;
        d0 = done_cnt;
        o0 = ovr_cnt;
        pulse_slot(32'd0);
        repeat (5) tick();
        check("D_zero_no_grant", 64'(grants_seen), 64'(g0));
        check("D_zero_busy", 64'(busy), 64'd0);
        check("D_zero_overrun", 64'(ovr_cnt), 64'(o0));

        // Finish held high through BUSY never completes; overrun in BUSY keeps budget.
        exp_q.push_back('{rr_model(4'b0001), 32'd100});
        pulse_slot(32'd100);
        wait_grant(g0 + 1);
        check("D_winner", 64'(last_id), 64'd0);
        fwd_req = '0;
        repeat (30) tick();
        o0 = ovr_cnt;
        pulse_slot(32'd9999);
        tick();
        check("D_busy_overrun", 64'(ovr_cnt), 64'(o0 + 1));
        check("D_byte_kept", 64'(fwd_byte), 64'd100);
        check("D_still_busy", 64'(busy), 64'd1);
        check("D_no_done", 64'(done_cnt), 64'(d0));

        // Asynchronous reset while BUSY clears outputs immediately.
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("E_async");
        tick();
        tick();
        rst_n = 1'b1;
        exp_rr = 0;
        tick();
        run_slot(4'b1111, 32'd42);
        check("E_after_reset", 64'(last_id), 64'd0);

`ifdef FWD_SCHED_TIMEOUT_EN
        // Finish never drops: watchdog aborts after P_TIMEOUT BUSY cycles.
        exp_q.push_back('{rr_model(4'b0100), 32'd55});
        g0 = grants_seen;
        d0 = done_cnt;
        t0 = tmo_cnt;
        fwd_req = 4'b0100;
        pulse_slot(32'd55);
        wait_grant(g0 + 1);
        fwd_req = '0;
        for (int k = 0; k < 80 && tmo_cnt == t0; k++) tick();
        tick();
        tick();
        check("F_timeout_pulse", 64'(tmo_cnt), 64'(t0 + 1));
        check("F_timeout_cycle", 64'(tmo_cyc - grant_cyc), 64'd51);
        check("F_no_done", 64'(done_cnt), 64'(d0));
        check("F_idle", 64'(busy), 64'd0);
        exp_rr = 3;
        run_slot(4'b1111, 32'd66);
        check("F_next_winner", 64'(last_id), 64'd3);
`else
        t0 = tmo_cnt;
        check("timeout_tied", 64'(t0), 64'd0);
`endif

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_watchdog: observed=stalled expected=finish");
        $fatal(1, "simulation did not finish");
    end
endmodule
